bof_range_guard: RTL and testbench
==================================

# bof_range_guard

Parametrised heap buffer-overflow guard beside the branch unit in the execute stage. It watches the issued load/store/JALR stream and detects runs of contiguous stores through non-stack base registers. Runs of at least MIN_RUN bytes are recorded in a DEPTH-entry circular range table. A JALR that follows a load from a recorded or active range raises crash/alert. It generalises the single-range heap tracker to a configurable address width, table depth, threshold and timeout, and adds a flush, a debug read port and a sticky alert.

## Interface
- ADDR_W, 32, address width in bits
- DEPTH, 8, range-table entries (≥2, power of two)
- MIN_RUN, 32, minimum run length in bytes for a run to be recorded
- TIMEOUT, 10, non-store valid ops before an active run closes (≤255)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous clear of tracker, table and taint
- valid_i  in  1  an op is issued this cycle
- op_i  in  2  op class, bof_op_e: OTHER, STORE, LOAD, JALR
- size_i  in  3  access bytes (1, 2 or 4); ignored unless STORE
- rs1_i  in  5  base register index
- addr_i  in  ADDR_W  effective address (imm + rs1)
- hit_o  out  1  current LOAD address lies in a tracked range
- crash_o  out  1  one-cycle pulse on a tainted JALR
- alert_o  out  1  sticky; set with crash_o, cleared only by reset
- count_o  out  $clog2(DEPTH+1)  valid table entries
- rd_idx_i  in  $clog2(DEPTH)  debug read index
- rd_start_o, rd_end_o  out  ADDR_W each  entry at rd_idx_i; zero if that entry is invalid

## Operation
- Tracker FSM has two states: IDLE and TRACK. Registers: start, next (the expected next address), run bytes (ADDR_W, saturating), timer.
- Qualifying store: valid_i, op_i==STORE, rs1_i not x2/x8. Stores through x2 or x8 are ignored entirely.
- IDLE + qualifying store: go to TRACK. start=addr_i, next=addr_i+size_i, run=size_i, timer=TIMEOUT.
- TRACK + qualifying store with addr_i==next: extend the run. next+=size_i, run+=size_i, timer reloads.
- TRACK + qualifying store elsewhere: close the current run and start a new run from this store in the same cycle.
- TRACK + valid non-store op: timer decrements. If the timer is 0, close the run and go to IDLE.
- Close: if run ≥ MIN_RUN, write [start, next-1] to the table at wr_ptr. wr_ptr advances mod DEPTH; when full, the oldest entry is overwritten. count saturates at DEPTH.
- Wrap rule: if next+size_i would overflow 2^ADDR_W, treat the store as non-contiguous.
- hit_o: LOAD addr_i inside any valid entry (inclusive bounds), or inside the active run [start, next-1].
- Taint (BOF_TAINT_EN): a LOAD sets taint_q=hit_o. A JALR with taint_q=1 fires crash_o. Every JALR clears taint_q.
- flush_i has priority over all other events: state to IDLE, all entries invalid, wr_ptr=0, taint_q=0. alert_o is kept.

## Timing
- Reset values: hit_o 0, crash_o 0, alert_o 0, count_o 0, rd_start_o/rd_end_o 0. FSM in IDLE, wr_ptr 0, taint_q 0.
- hit_o is combinational from addr_i against registered table and tracker state.
- A committed entry is visible to hit_o and count_o from the cycle after the closing event.
- A load in the same cycle as the close still hits, via the active-run term.
- crash_o is registered: it asserts the cycle after the tainted JALR, for exactly one cycle. alert_o rises on the same edge.
- A LOAD followed by a JALR in the very next valid op sees the updated taint.
- Cycles with valid_i=0 change no state.
- The debug read port is combinational.

## Configuration
- Macro BOF_TAINT_EN.
- Defined: taint register and crash logic are present as described above.
- Undefined: taint_q is removed, crash_o and alert_o are tied 0. Range recording and hit_o are unchanged.

## Structure
- Shared package bof_pkg holds: the bof_op_e enum, the bof_range_t struct (start, end_, valid), and the excluded-register constants (2, 8).
- Natural sub-module: bof_range_table. It holds the DEPTH-entry circular store with write pointer, count, parallel inclusive-range compare and the debug read port.

## Test plan
- Contiguous run: 10 SW through x10 from 0x1000 to 0x1024, then 10 OTHER ops. Required: entry [0x1000,0x1027] recorded; count_o=1 one cycle after the 10th OTHER.
- Short run: 4 SW from 0x2000, then a SW at 0x3000. Required: nothing recorded (run 16 < 32); new run starts at 0x3000.
- Stack exclusion: 20 SW through x2 or x8 to contiguous addresses. Required: FSM stays IDLE; count_o=0.
- Wrap-around: 9 recorded runs with DEPTH=8. Required: count_o=8, the first run is evicted (load to it gives hit_o=0), the 9th sits at index 0.
- Taint path: after the first scenario, LW 0x1010 then JALR. Required: hit_o=1 on the LW; crash_o pulses 1 cycle after the JALR; alert_o stays 1. LW 0x5000 then JALR gives no crash.
- flush_i during TRACK with 3 entries stored. Required: count_o=0 next cycle, hit_o=0 for old ranges, alert_o unchanged.

Source files
------------

// File: rtl/bof_pkg.sv
// bof_pkg: op encoding, range-entry type, tracker states and excluded base registers for bof_range_guard
package bof_pkg;
   localparam int BOF_AW_MAX = 64;
   localparam logic [4:0] BOF_REG_SP = 5'd2;
   localparam logic [4:0] BOF_REG_FP = 5'd8;
   typedef enum logic [1:0] {OP_OTHER, OP_STORE, OP_LOAD, OP_JALR} bof_op_e;
   typedef enum logic {IDLE, TRACK} bof_state_e;
   typedef struct packed {
      logic [BOF_AW_MAX-1:0] start;
      logic [BOF_AW_MAX-1:0] end_;
      logic                  valid;
   } bof_range_t;
endpackage

// File: rtl/bof_range_table.sv
// bof_range_table: DEPTH-entry circular range store with parallel inclusive lookup and debug read port
module bof_range_table
   import bof_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       wr_en_i,
   input  logic [ADDR_W-1:0]          wr_start_i,
   input  logic [ADDR_W-1:0]          wr_end_i,
   input  logic [ADDR_W-1:0]          lk_addr_i,
   output logic                       lk_hit_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
   output logic [ADDR_W-1:0]          rd_start_o,
   output logic [ADDR_W-1:0]          rd_end_o
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   bof_range_t tbl_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [BOF_AW_MAX-1:0] lk_addr;
   assign lk_addr = BOF_AW_MAX'(lk_addr_i);
   // Entry writes with pointer wrap (oldest overwritten) and saturating occupancy; flush drops every entry
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
         wr_ptr_q <= '0;
         count_o <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) tbl_q[i].valid <= 1'b0;
         wr_ptr_q <= '0;
         count_o <= '0;
      end else if (wr_en_i) begin
         tbl_q[wr_ptr_q] <= '{start: BOF_AW_MAX'(wr_start_i), end_: BOF_AW_MAX'(wr_end_i), valid: 1'b1};
         wr_ptr_q <= wr_ptr_q + PW'(1);
         count_o <= (count_o == CW'(DEPTH)) ? count_o : count_o + CW'(1);
      end
   end
   // Parallel inclusive compare against every valid entry
   always_comb begin
      lk_hit_o = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         lk_hit_o = lk_hit_o | (tbl_q[i].valid && lk_addr >= tbl_q[i].start && lk_addr <= tbl_q[i].end_);
   end
   assign rd_start_o = tbl_q[rd_idx_i].valid ? tbl_q[rd_idx_i].start[ADDR_W-1:0] : '0;
   assign rd_end_o   = tbl_q[rd_idx_i].valid ? tbl_q[rd_idx_i].end_[ADDR_W-1:0] : '0;
endmodule

// File: rtl/bof_range_guard.sv
// bof_range_guard: tracks contiguous non-stack store runs, records long ones, flags loads into them.
// Macro BOF_TAINT_EN adds the load->JALR taint register driving crash_o/alert_o; otherwise both are tied low.
module bof_range_guard
   import bof_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 8,
   parameter int MIN_RUN = 32,
   parameter int TIMEOUT = 10
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       valid_i,
   input  logic [1:0]                 op_i,
   input  logic [2:0]                 size_i,
   input  logic [4:0]                 rs1_i,
   input  logic [ADDR_W-1:0]          addr_i,
   output logic                       hit_o,
   output logic                       crash_o,
   output logic                       alert_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
   output logic [ADDR_W-1:0]          rd_start_o,
   output logic [ADDR_W-1:0]          rd_end_o
);
   localparam logic [7:0] TMO = 8'(TIMEOUT);
   bof_state_e state_q, state_d;
   logic [ADDR_W-1:0] start_q, next_q, run_q, sz, nxt_sum, run_sum, run_sat, act_end;
   logic [7:0] timer_q;
   logic nxt_ovf, run_ovf, qs, tick, contig, close, rec, tbl_hit, is_ld;
   assign sz = ADDR_W'(size_i);
   assign {nxt_ovf, nxt_sum} = {1'b0, next_q} + {1'b0, sz};
   assign {run_ovf, run_sum} = {1'b0, run_q} + {1'b0, sz};
   assign run_sat = run_ovf ? '1 : run_sum;
   assign act_end = next_q - ADDR_W'(1);
   assign qs = valid_i && op_i == OP_STORE && rs1_i != BOF_REG_SP && rs1_i != BOF_REG_FP;
   assign tick = valid_i && op_i != OP_STORE;
   assign contig = state_q == TRACK && addr_i == next_q && !nxt_ovf;
   assign close = state_q == TRACK && ((qs && !contig) || (tick && timer_q <= 8'd1));
   assign rec = close && run_q >= ADDR_W'(MIN_RUN);
   // Tracker state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else state_q <= flush_i ? IDLE : state_d;
   end
   // Any qualifying store (re)opens a run; a close without one returns to IDLE
   always_comb state_d = qs ? TRACK : close ? IDLE : state_q;
   // Run bookkeeping: extend on contiguous store, restart on a jump, count down on other ops
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         start_q <= '0;
         next_q <= '0;
         run_q <= '0;
         timer_q <= '0;
      end else if (!flush_i) begin
         if (qs) begin
            start_q <= contig ? start_q : addr_i;
            next_q <= contig ? nxt_sum : addr_i + sz;
            run_q <= contig ? run_sat : sz;
            timer_q <= TMO;
         end else if (tick && state_q == TRACK) timer_q <= timer_q - 8'd1;
      end
   end
   // Load hit against committed entries or the still-open run
   always_comb begin
      is_ld = valid_i && op_i == OP_LOAD;
      hit_o = is_ld && (tbl_hit || (state_q == TRACK && addr_i >= start_q && addr_i <= act_end));
   end
   bof_range_table #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_table (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush_i   (flush_i),
      .wr_en_i   (rec),
      .wr_start_i(start_q),
      .wr_end_i  (act_end),
      .lk_addr_i (addr_i),
      .lk_hit_o  (tbl_hit),
      .count_o   (count_o),
      .rd_idx_i  (rd_idx_i),
      .rd_start_o(rd_start_o),
      .rd_end_o  (rd_end_o)
   );
`ifdef BOF_TAINT_EN
   logic taint_q, jalr;
   assign jalr = valid_i && op_i == OP_JALR;
   // Taint follows the last load's hit; a JALR consumes it and fires the one-cycle crash pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         taint_q <= 1'b0;
         crash_o <= 1'b0;
         alert_o <= 1'b0;
      end else if (flush_i) begin
         taint_q <= 1'b0;
         crash_o <= 1'b0;
      end else begin
         crash_o <= jalr && taint_q;
         alert_o <= alert_o || (jalr && taint_q);
         taint_q <= is_ld ? hit_o : jalr ? 1'b0 : taint_q;
      end
   end
`else
   assign crash_o = 1'b0;
   assign alert_o = 1'b0;
`endif
endmodule

// File: tb/tb_bof_range_guard.sv
// tb_bof_range_guard: scoreboard bench; expectations queued at drive time, compared as outputs appear
module tb_bof_range_guard;
   import bof_pkg::*;
   localparam int S_HIT = 0, S_CNT = 1, S_CRASH = 2, S_ALERT = 3, S_RDS = 4, S_RDE = 5;
`ifdef BOF_TAINT_EN
   localparam logic [31:0] TNT = 32'd1;
`else
   localparam logic [31:0] TNT = 32'd0;
`endif
   typedef struct {
      string       tag;
      int          sig;
      logic [31:0] val;
      int          due;
   } sb_t;
   logic clk_i = 1'b0, rst_ni, flush_i, valid_i, hit_o, crash_o, alert_o;
   logic [1:0] op_i;
   logic [2:0] size_i, rd_idx_i;
   logic [4:0] rs1_i;
   logic [31:0] addr_i, rd_start_o, rd_end_o;
   logic [3:0] count_o;
   sb_t sb[$];
   int cyc = 0, n_chk = 0, n_pass = 0;
   bof_range_guard dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .op_i(op_i),
      .size_i(size_i), .rs1_i(rs1_i), .addr_i(addr_i), .hit_o(hit_o), .crash_o(crash_o),
      .alert_o(alert_o), .count_o(count_o), .rd_idx_i(rd_idx_i), .rd_start_o(rd_start_o),
      .rd_end_o(rd_end_o)
   );
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
   endtask
   function automatic logic [31:0] act_of(input int s);
      case (s)
         S_HIT:   return {31'd0, hit_o};
         S_CNT:   return {28'd0, count_o};
         S_CRASH: return {31'd0, crash_o};
         S_ALERT: return {31'd0, alert_o};
         S_RDS:   return rd_start_o;
         default: return rd_end_o;
      endcase
   endfunction
   always @(negedge clk_i) begin
      sb_t e;
      while (sb.size() != 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         chk(e.tag, act_of(e.sig), e.val);
      end
   end
   task automatic want(input int s, input logic [31:0] v, input int d, input string t);
      sb_t e;
      e.tag = t;
      e.sig = s;
      e.val = v;
      e.due = cyc + d;
      sb.push_back(e);
   endtask
   task automatic drive(input logic v, input bof_op_e o, input logic [4:0] r, input logic [31:0] a, input logic f);
      @(posedge clk_i);
      #1;
      valid_i = v;
      op_i = o;
      rs1_i = r;
      addr_i = a;
      size_i = 3'd4;
      flush_i = f;
   endtask
   task automatic st(input logic [4:0] r, input logic [31:0] a);
      drive(1'b1, OP_STORE, r, a, 1'b0);
   endtask
   task automatic ld(input logic [31:0] a, input logic h, input string t);
      drive(1'b1, OP_LOAD, 5'd10, a, 1'b0);
      want(S_HIT, {31'd0, h}, 0, t);
   endtask
   task automatic oth();
      drive(1'b1, OP_OTHER, 5'd0, 32'd0, 1'b0);
   endtask
   task automatic jalr();
      drive(1'b1, OP_JALR, 5'd1, 32'd0, 1'b0);
   endtask
   task automatic idle();
      drive(1'b0, OP_OTHER, 5'd0, 32'd0, 1'b0);
   endtask
   initial begin
      rst_ni = 1'b0;
      flush_i = 1'b0;
      valid_i = 1'b0;
      op_i = OP_OTHER;
      size_i = 3'd0;
      rs1_i = 5'd0;
      addr_i = 32'd0;
      rd_idx_i = 3'd0;
      repeat (3) @(posedge clk_i);
      #2 rst_ni = 1'b1;
      idle();
      want(S_HIT, 0, 0, "rst_hit");
      want(S_CNT, 0, 0, "rst_cnt");
      want(S_CRASH, 0, 0, "rst_crash");
      want(S_ALERT, 0, 0, "rst_alert");
      want(S_RDS, 0, 0, "rst_rds");
      want(S_RDE, 0, 0, "rst_rde");
      for (int i = 0; i < 10; i++) st(5'd10, 32'h1000 + 4 * i);
      for (int i = 0; i < 9; i++) oth();
      want(S_CNT, 0, 1, "run_open");
      repeat (5) idle();
      want(S_CNT, 0, 1, "idle_hold");
      oth();
      want(S_CNT, 1, 1, "run_rec");
      idle();
      want(S_RDS, 32'h1000, 0, "run_start");
      want(S_RDE, 32'h1027, 0, "run_end");
      ld(32'h1027, 1'b1, "hit_end");
      ld(32'h1028, 1'b0, "miss_past");
      ld(32'h0fff, 1'b0, "miss_below");
      ld(32'h1010, 1'b1, "taint_ld");
      jalr();
      want(S_CRASH, TNT, 1, "crash");
      want(S_ALERT, TNT, 1, "alert");
      idle();
      want(S_CRASH, 0, 1, "crash_pulse");
      want(S_ALERT, TNT, 1, "alert_sticky");
      ld(32'h5000, 1'b0, "clean_ld");
      jalr();
      want(S_CRASH, 0, 1, "no_crash");
      want(S_ALERT, TNT, 1, "alert_kept");
      for (int i = 0; i < 3; i++) st(5'd11, 32'h2000 + 4 * i);
      ld(32'h2008, 1'b1, "act_hit");
      st(5'd11, 32'h200c);
      st(5'd11, 32'h3000);
      want(S_CNT, 1, 1, "short_norec");
      ld(32'h2000, 1'b0, "short_gone");
      ld(32'h3000, 1'b1, "new_run");
      ld(32'h3004, 1'b0, "new_run_end");
      repeat (10) oth();
      want(S_CNT, 1, 1, "short2_norec");
      for (int i = 0; i < 20; i++) st((i % 2) ? 5'd8 : 5'd2, 32'h4000 + 4 * i);
      ld(32'h4000, 1'b0, "stack_nohit");
      want(S_CNT, 1, 1, "stack_cnt");
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < 8; i++) begin
            st(5'd12, 32'h8000 + 256 * k + 4 * i);
            if (k > 0 && i == 0) want(S_CNT, 1 + k, 1, "wrap_fill");
         end
      st(5'd12, 32'h9000);
      want(S_CNT, 8, 1, "wrap_sat");
      repeat (10) oth();
      idle();
      want(S_RDS, 32'h8700, 0, "wrap_idx0_s");
      want(S_RDE, 32'h871f, 0, "wrap_idx0_e");
      idle();
      rd_idx_i = 3'd1;
      want(S_RDS, 32'h8000, 0, "wrap_idx1_s");
      want(S_RDE, 32'h801f, 0, "wrap_idx1_e");
      ld(32'h1010, 1'b0, "evicted");
      ld(32'h8000, 1'b1, "wrap_first");
      ld(32'h871f, 1'b1, "wrap_last");
      ld(32'h8720, 1'b0, "wrap_past");
      drive(1'b0, OP_OTHER, 5'd0, 32'd0, 1'b1);
      want(S_CNT, 0, 1, "flush0_cnt");
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 8; i++) st(5'd14, 32'ha000 + 256 * k + 4 * i);
      st(5'd14, 32'ha300);
      want(S_CNT, 3, 1, "three_cnt");
      st(5'd14, 32'ha304);
      ld(32'ha000, 1'b1, "pre_flush_hit");
      jalr();
      want(S_CRASH, TNT, 1, "pre_flush_crash");
      want(S_ALERT, TNT, 1, "pre_flush_alert");
      drive(1'b1, OP_STORE, 5'd14, 32'ha308, 1'b1);
      want(S_CNT, 0, 1, "flush_cnt");
      want(S_ALERT, TNT, 1, "flush_alert");
      want(S_CRASH, 0, 1, "flush_crash");
      rd_idx_i = 3'd0;
      ld(32'ha000, 1'b0, "flush_old");
      want(S_RDS, 0, 0, "flush_rds");
      ld(32'ha304, 1'b0, "flush_act");
      for (int i = 0; i < 8; i++) st(5'd13, 32'hb000 + 4 * i);
      repeat (10) oth();
      idle();
      want(S_CNT, 1, 0, "post_cnt");
      want(S_RDS, 32'hb000, 0, "post_rds");
      want(S_RDE, 32'hb01f, 0, "post_rde");
      idle();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk_i);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
